fifo_rd_stream_adapter: RTL and testbench

- Read-side consumer for the synchronous FIFO: drives the FIFO's rd/empty/Rdata port and re-presents the words as a valid/ready stream with full throughput and backpressure.
- Sits between the sync FIFO read port and any downstream stream sink.
- Absorbs the FIFO's 1-cycle read latency with a 2-entry output buffer.
- Counts delivered words for debug and scoreboarding.

---
 rtl/fifo_rd_stream_adapter.sv | 86 ++++++++
 tb/tb_fifo_rd_stream_adapter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream_adapter.sv
// Read-side adapter for the synchronous FIFO: issues reads against the FIFO's
// 1-cycle read latency and re-presents the words as a valid/ready stream.
`default_nettype none

module fifo_rd_stream_adapter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_rd,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] tx_count
);

  logic [WIDTH-1:0] r_buf [0:1];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_occ;
  logic             r_pend;
  logic [CNT_W-1:0] r_tx_count;

  logic       w_pop;
  logic       w_credit;
  logic       w_rd;
  logic [2:0] w_inflight;

  // Words already buffered plus the one still coming back from the FIFO.
  assign w_inflight = {1'b0, r_occ} + {2'b00, r_pend};

  assign m_valid  = (r_occ != 2'd0);
  assign m_data   = r_buf[r_rd_ptr];
  assign w_pop    = m_valid && m_ready;

  // A pop this cycle frees a slot before the word read now can land, which is
  // what lets m_ready reach fifo_rd combinationally for full throughput.
  assign w_credit = (w_inflight < 3'd2) || w_pop;
  assign w_rd     = !reset && en && !fifo_empty && w_credit;
  assign fifo_rd  = w_rd;
  assign tx_count = r_tx_count;

  // Capture is unconditional on pend: credit accounting guarantees a free slot.
  always_ff @(posedge clk) begin
    if (r_pend) begin
      r_buf[r_wr_ptr] <= fifo_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_occ      <= 2'd0;
      r_pend     <= 1'b0;
      r_tx_count <= '0;
    end else begin
      r_pend <= w_rd;
      if (r_pend) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr   <= ~r_rd_ptr;
        r_tx_count <= r_tx_count + CNT_W'(1);
      end
      case ({r_pend, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  a_occ_max: assert property (@(posedge clk) disable iff (reset) r_occ <= 2'd2);
  a_credit: assert property (@(posedge clk) disable iff (reset) w_inflight <= 3'd2);
  a_no_rd_empty: assert property (@(posedge clk) disable iff (reset) !(fifo_rd && fifo_empty));
  a_stall_hold: assert property (@(posedge clk) disable iff (reset)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: behavioural FIFO plus word-conservation
// scoreboard; a negedge monitor checks every cycle and every handshake.
module tb_fifo_rd_stream_adapter;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int DEPTH = 1024;
  localparam int LIMIT = 5000;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             en = 1'b0;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] fifo_rdata = '0;
  logic             fifo_empty;
  logic             fifo_rd;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic [CNT_W-1:0] tx_count;

  logic [WIDTH-1:0] fifo_mem [0:DEPTH-1];
  logic [WIDTH-1:0] exp_mem [0:DEPTH-1];
  int wr_total = 0;
  int rd_total = 0;
  int consumed = 0;
  bit done = 1'b0;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int ntx = 0;
  bit prev_rd = 1'b0;
  bit prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  logic [CNT_W-1:0] model_tx = '0;

  always #5 clk = ~clk;

  fifo_rd_stream_adapter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .en(en), .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata), .fifo_rd(fifo_rd), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .tx_count(tx_count)
  );

  // Behavioural sync FIFO: read data appears the cycle after an accepted rd.
  assign fifo_empty = (wr_total == rd_total);
  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_rdata <= fifo_mem[rd_total % DEPTH];
      rd_total   <= rd_total + 1;
    end
  end

  task automatic push(input logic [WIDTH-1:0] w);
    fifo_mem[wr_total % DEPTH] = w;
    exp_mem[wr_total % DEPTH]  = w;
    wr_total++;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Monitor: words fetched from the FIFO but not yet delivered are in flight;
  // a reset discards them, a handshake consumes the oldest one.
  always @(negedge clk) begin
    int inflight;
    bit exp_valid;
    bit exp_rd;
    cycle++;
    if (reset) begin
      check(m_valid == 1'b0, "rst_m_valid", int'(m_valid), 0);
      check(fifo_rd == 1'b0, "rst_fifo_rd", int'(fifo_rd), 0);
      check(tx_count == '0, "rst_tx_count", int'(tx_count), 0);
      consumed   = rd_total;
      model_tx   = '0;
      prev_rd    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      inflight  = rd_total - consumed;
      exp_valid = (inflight - int'(prev_rd)) > 0;
      exp_rd    = en && !fifo_empty && ((inflight < 2) || (exp_valid && m_ready));
      check(inflight <= 2, "inflight_max", inflight, 2);
      check(m_valid == exp_valid, "m_valid", int'(m_valid), int'(exp_valid));
      check(fifo_rd == exp_rd, "fifo_rd", int'(fifo_rd), int'(exp_rd));
      check(tx_count == model_tx, "tx_count", int'(tx_count), int'(model_tx));
      if (prev_stall) begin
        check(m_data == prev_data, "stall_hold", int'(m_data), int'(prev_data));
      end
      if (m_valid && m_ready) begin
        check(consumed < wr_total, "underflow", consumed, wr_total);
        check(m_data == exp_mem[consumed % DEPTH], "data", int'(m_data),
              int'(exp_mem[consumed % DEPTH]));
        $display("tx %0d data %02h tx_count %0d", ntx, m_data, tx_count);
        ntx++;
        consumed++;
        model_tx++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_rd    = fifo_rd;
    end
    if (done || cycle > LIMIT) begin
      check(cycle <= LIMIT, "timeout", cycle, LIMIT);
      check(consumed == wr_total, "drain", consumed, wr_total);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    #1;
    reset = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    step(3);
    reset = 1'b0; en = 1'b1; m_ready = 1'b1;
    step(8);

    en = 1'b0;
    for (int i = 0; i < 16; i++) push(WIDTH'(i));
    step(1);
    en = 1'b1;
    step(24);

    for (int i = 0; i < 8; i++) push(8'hA0 + WIDTH'(i));
    step(3);
    m_ready = 1'b0;
    step(6);
    m_ready = 1'b1;
    step(15);

    step(5);
    push(8'h5A);
    step(6);

    en = 1'b0;
    push(8'hC1); push(8'hC2);
    step(1);
    en = 1'b1;
    step(1);
    en = 1'b0;
    step(6);
    en = 1'b1;
    step(6);

    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'hD0 + WIDTH'(i));
    step(5);
    reset = 1'b1;
    step(2);
    reset = 1'b0; m_ready = 1'b1;
    step(15);

    repeat (600) begin
      if ($urandom_range(0, 2) == 0) push(WIDTH'($urandom));
      en      = ($urandom_range(0, 7) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      reset   = ($urandom_range(0, 149) == 0);
      step(1);
    end

    reset = 1'b0; en = 1'b1; m_ready = 1'b1;
    step(40);
    done = 1'b1;
  end

endmodule
